// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: FSM state encoding, default sizing and grant helper
// shared by apb_arb_master and its round-robin arbiter.
package apb_arb_pkg;

  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TO_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_ACCESS   = 2'd2,
    ST_COMPLETE = 2'd3
  } apb_state_t;

  // Expand a requester index into its one-hot done/grant vector.
  function automatic logic [1:0] grant_onehot(input logic grant_idx);
    grant_onehot = grant_idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_arb_master_rr_arb2.sv
// rr_arb2: two-way round-robin grant selection. A lone requester always
// wins; on a tie the requester that was not served last time wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_grant
);

  // Select the grant index from the request vector and last-grant pointer.
  always_comb begin
    o_grant = 1'b0;
    case (i_req)
      2'b01:   o_grant = 1'b0;
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = ~i_last;
      default: o_grant = ~i_last;
    endcase
  end

endmodule

// File: rtl/apb_arb_master.sv
// apb_arb_master: two-requester APB master with round-robin arbitration.
// One transfer at a time walks IDLE -> SETUP -> ACCESS -> COMPLETE.
// Optional macro APB_TIMEOUT_EN bounds the ACCESS wait states to
// TO_CYCLES, ending the transfer with err=1 and rdata=0.
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TO_CYCLES = DEF_TO_CYCLES
) (
  input  logic              Pclk,
  input  logic              Prst,
  input  logic [1:0]        req,
  input  logic [1:0]        wr,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] Paddr,
  output logic              Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [DATA_W-1:0] Pwdata,
  input  logic              Pready,
  input  logic              Pslverr,
  input  logic [DATA_W-1:0] Prdata
);

  apb_state_t        r_state;
  apb_state_t        w_state_nxt;
  logic              r_last;
  logic              r_grant;
  logic              w_grant;
  logic              w_start;
  logic              w_to_hit;
  logic [1:0]        r_done;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;

  rr_arb2 u_rr_arb2 (
    .i_req   (req),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  assign w_start = (r_state == ST_IDLE) && (|req);

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  logic [TO_W-1:0] r_to_cnt;

  // Count consecutive unready ACCESS cycles; restart on every new transfer.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      r_to_cnt <= '0;
    end else if (w_start) begin
      r_to_cnt <= '0;
    end else if ((r_state == ST_ACCESS) && !Pready) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end

  assign w_to_hit = (r_state == ST_ACCESS) && !Pready &&
                    (r_to_cnt == TO_W'(TO_CYCLES - 1));
`else
  // Timeout disabled: never fires (keeps TO_CYCLES referenced in this build).
  assign w_to_hit = 1'b0 & (TO_CYCLES == 0);
`endif

  // FSM state register.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|req) w_state_nxt = ST_SETUP;
        else      w_state_nxt = ST_IDLE;
      end
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (Pready || w_to_hit) w_state_nxt = ST_COMPLETE;
        else                    w_state_nxt = ST_ACCESS;
      end
      ST_COMPLETE: w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant/latch request fields, capture the response and register APB controls.
  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      r_last    <= 1'b1;
      r_grant   <= 1'b0;
      r_done    <= 2'b00;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_paddr   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_grant  <= w_grant;
            r_last   <= w_grant;
            r_pwrite <= wr[w_grant];
            r_paddr  <= w_grant ? addr1 : addr0;
            r_pwdata <= w_grant ? wdata1 : wdata0;
          end else begin
            r_grant  <= r_grant;
          end
        end
        ST_ACCESS: begin
          if (Pready) begin
            r_err <= Pslverr;
            if (!r_pwrite) r_rdata <= Prdata;
            else           r_rdata <= r_rdata;
          end else if (w_to_hit) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_err   <= r_err;
          end
        end
        default: begin
          r_grant <= r_grant;
        end
      endcase
      r_psel    <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
      r_penable <= (w_state_nxt == ST_ACCESS);
      r_done    <= (w_state_nxt == ST_COMPLETE) ? grant_onehot(r_grant) : 2'b00;
    end
  end

  assign done    = r_done;
  assign rdata   = r_rdata;
  assign err     = r_err;
  assign Paddr   = r_paddr;
  assign Pselx   = r_psel;
  assign Penable = r_penable;
  assign Pwrite  = r_pwrite;
  assign Pwdata  = r_pwdata;

endmodule

// File: tb/tb_apb_arb_master.sv
// tb_apb_arb_master: self-checking bench for apb_arb_master. The bench acts
// as both requesters and the APB slave; expectations come from a
// transaction-level model (round-robin pointer, slave memory, last response).
module tb_apb_arb_master;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          Pclk = 1'b0;
  logic          Prst;
  logic [1:0]    req;
  logic [1:0]    wr;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    done;
  logic [DW-1:0] rdata;
  logic          err;
  logic [AW-1:0] Paddr;
  logic          Pselx, Penable, Pwrite;
  logic [DW-1:0] Pwdata;
  logic          Pready, Pslverr;
  logic [DW-1:0] Prdata;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic          m_last;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] mem [0:63];

  apb_arb_master #(.ADDR_W(AW), .DATA_W(DW), .TO_CYCLES(TO)) dut (
    .Pclk(Pclk), .Prst(Prst), .req(req), .wr(wr),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done(done), .rdata(rdata), .err(err),
    .Paddr(Paddr), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Pwdata(Pwdata), .Pready(Pready), .Pslverr(Pslverr), .Prdata(Prdata)
  );

  always #5 Pclk = ~Pclk;

  // Run one transfer from an IDLE cycle; acts as slave, records observations only.
  task automatic xfer(input logic [1:0] rq, input int waits, input logic slverr,
                      input logic [DW-1:0] prd, output int lat,
                      output logic [1:0] dv, output logic [1:0] da,
                      output logic [AW-1:0] oa, output logic [DW-1:0] ow,
                      output logic owr, output logic s_ok, output logic st_ok,
                      output logic c_ok);
    int k;
    bit fin;
    req = req | rq;
    lat = -1; dv = 2'b00; da = 2'b11; oa = '0; ow = '0; owr = 1'b0;
    s_ok = 1'b0; st_ok = 1'b1; c_ok = 1'b0; k = 0; fin = 1'b0;
    for (int c = 1; c <= 200 && !fin; c++) begin
      @(posedge Pclk); #1;
      if (c == 1) begin
        s_ok = (Pselx === 1'b1) && (Penable === 1'b0);
        oa = Paddr; ow = Pwdata; owr = Pwrite;
      end else if (Penable === 1'b1) begin
        if (Paddr !== oa || Pwdata !== ow || Pwrite !== owr || Pselx !== 1'b1) st_ok = 1'b0;
      end
      if (Penable === 1'b1) begin
        k++;
        Pready  = (k > waits);
        Pslverr = (k > waits) ? slverr : 1'($urandom % 2);
        Prdata  = (k > waits) ? prd : DW'($urandom);
      end else begin
        Pready = 1'b0; Pslverr = 1'($urandom % 2); Prdata = DW'($urandom);
      end
      if (done !== 2'b00) begin
        lat = c; dv = done;
        c_ok = (Pselx === 1'b0) && (Penable === 1'b0);
        req = req & ~done;
        Pready = 1'b0;
        fin = 1'b1;
      end
    end
    if (fin) begin
      @(posedge Pclk); #1;
      da = done;
    end
  endtask

  task automatic apply_reset();
    Prst = 1'b1; req = 2'b00; Pready = 1'b0;
    @(posedge Pclk); #1;
    Prst = 1'b0;
    m_last = 1'b1; m_rdata = '0;
  endtask

  task automatic test_reset();
    Prst = 1'b1; req = 2'b00; wr = 2'b00; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
    @(posedge Pclk); #1;
    checks++;
    if ({Pselx, Penable, Pwrite, done, err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got sel=%b en=%b wr=%b done=%b err=%b expected all 0",
               Pselx, Penable, Pwrite, done, err);
    end
    checks++;
    if ({Paddr, Pwdata, rdata} !== {(AW + 2 * DW){1'b0}}) begin
      failures++;
      $display("FAIL reset_data: got addr=%0h wdata=%0h rdata=%0h expected 0", Paddr, Pwdata, rdata);
    end
    Prst = 1'b0;
    m_last = 1'b1; m_rdata = '0;
  endtask

  task automatic test_single_write();
    int lat; logic [1:0] dv, da; logic [AW-1:0] oa; logic [DW-1:0] ow;
    logic owr, s_ok, st_ok, c_ok;
    wr[0] = 1'b1; addr0 = 6'd5; wdata0 = 32'hA5A5_0001;
    xfer(2'b01, 0, 1'b0, 32'h0, lat, dv, da, oa, ow, owr, s_ok, st_ok, c_ok);
    m_last = 1'b0;
    checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++; if (dv !== 2'b01) begin failures++; $display("FAIL wr_done: got %b expected 01", dv); end
    checks++; if (s_ok !== 1'b1) begin failures++; $display("FAIL wr_setup: got %b expected 1", s_ok); end
    checks++;
    if (oa !== 6'd5 || ow !== 32'hA5A5_0001 || owr !== 1'b1) begin
      failures++; $display("FAIL wr_bus: got addr=%0h wdata=%0h wr=%b expected 5 a5a50001 1", oa, ow, owr);
    end
    checks++; if (st_ok !== 1'b1) begin failures++; $display("FAIL wr_stable: got %b expected 1", st_ok); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL wr_err: got %b expected 0", err); end
    checks++; if (da !== 2'b00) begin failures++; $display("FAIL wr_done_width: got %b expected 00", da); end
  endtask

  task automatic test_read_wait();
    int lat; logic [1:0] dv, da; logic [AW-1:0] oa; logic [DW-1:0] ow;
    logic owr, s_ok, st_ok, c_ok;
    wr[0] = 1'b0; addr0 = 6'd5;
    xfer(2'b01, 2, 1'b0, 32'hA5A5_0001, lat, dv, da, oa, ow, owr, s_ok, st_ok, c_ok);
    m_last = 1'b0; m_rdata = 32'hA5A5_0001;
    checks++; if (lat !== 5) begin failures++; $display("FAIL rd_latency: got %0d expected 5", lat); end
    checks++; if (dv !== 2'b01) begin failures++; $display("FAIL rd_done: got %b expected 01", dv); end
    checks++; if (rdata !== m_rdata) begin failures++; $display("FAIL rd_data: got %0h expected %0h", rdata, m_rdata); end
    checks++; if (owr !== 1'b0 || oa !== 6'd5) begin failures++; $display("FAIL rd_bus: got wr=%b addr=%0h expected 0 5", owr, oa); end
    checks++; if (st_ok !== 1'b1) begin failures++; $display("FAIL rd_stable: got %b expected 1", st_ok); end
  endtask

  task automatic test_slverr();
    int lat; logic [1:0] dv, da; logic [AW-1:0] oa; logic [DW-1:0] ow;
    logic owr, s_ok, st_ok, c_ok; logic [DW-1:0] prd;
    wr[1] = 1'b1; addr1 = 6'($urandom); wdata1 = DW'($urandom);
    xfer(2'b10, 0, 1'b1, DW'($urandom), lat, dv, da, oa, ow, owr, s_ok, st_ok, c_ok);
    m_last = 1'b1;
    checks++; if (dv !== 2'b10) begin failures++; $display("FAIL err_done: got %b expected 10", dv); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_flag: got %b expected 1", err); end
    checks++; if (rdata !== m_rdata) begin failures++; $display("FAIL err_wr_rdata: got %0h expected %0h", rdata, m_rdata); end
    prd = DW'($urandom);
    wr[0] = 1'b0; addr0 = 6'($urandom);
    xfer(2'b01, 1, 1'b0, prd, lat, dv, da, oa, ow, owr, s_ok, st_ok, c_ok);
    m_last = 1'b0; m_rdata = prd;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b expected 0", err); end
    checks++; if (rdata !== m_rdata || lat !== 4) begin failures++; $display("FAIL err_rd: got %0h lat %0d expected %0h lat 4", rdata, lat, m_rdata); end
  endtask

  task automatic test_contention();
    int lat; logic [1:0] dv, da; logic [AW-1:0] oa; logic [DW-1:0] ow;
    logic owr, s_ok, st_ok, c_ok; logic g;
    apply_reset();
    wr = 2'b11; addr0 = 6'd10; addr1 = 6'd20; wdata0 = DW'($urandom); wdata1 = DW'($urandom);
    for (int i = 0; i < 4; i++) begin
      req = 2'b11;
      g = ~m_last;
      xfer(2'b11, 0, 1'b0, 32'h0, lat, dv, da, oa, ow, owr, s_ok, st_ok, c_ok);
      m_last = g;
      checks++;
      if (dv !== (g ? 2'b10 : 2'b01) || oa !== (g ? 6'd20 : 6'd10)) begin
        failures++; $display("FAIL rr_order[%0d]: got done=%b addr=%0h expected grant %0d", i, dv, oa, g);
      end
      checks++;
      if (c_ok !== 1'b1 || lat !== 3) begin
        failures++; $display("FAIL rr_complete[%0d]: got idle_bus=%b lat=%0d expected 1 3", i, c_ok, lat);
      end
    end
    req = 2'b00;
  endtask

  task automatic test_random();
    int lat; logic [1:0] dv, da; logic [AW-1:0] oa; logic [DW-1:0] ow;
    logic owr, s_ok, st_ok, c_ok;
    logic [1:0] nrq, comb; logic g, ewr, se; logic [AW-1:0] ea; logic [DW-1:0] ewd, prd;
    int waits;
    for (int j = 0; j < 64; j++) mem[j] = DW'($urandom);
    for (int i = 0; i < 24 || req != 2'b00; i++) begin
      nrq = (i < 24) ? 2'(1 + $urandom % 3) : 2'b00;
      if (nrq[0] && !req[0]) begin wr[0] = 1'($urandom % 2); addr0 = 6'($urandom); wdata0 = DW'($urandom); end
      if (nrq[1] && !req[1]) begin wr[1] = 1'($urandom % 2); addr1 = 6'($urandom); wdata1 = DW'($urandom); end
      comb = req | nrq;
      g    = (comb == 2'b11) ? ~m_last : comb[1];
      ewr  = wr[g];
      ea   = g ? addr1 : addr0;
      ewd  = g ? wdata1 : wdata0;
      se   = ($urandom % 8) == 0;
      waits = $urandom % 4;
      prd  = ewr ? DW'($urandom) : mem[ea];
      xfer(nrq, waits, se, prd, lat, dv, da, oa, ow, owr, s_ok, st_ok, c_ok);
      m_last = g;
      if (!ewr) m_rdata = prd;
      else if (!se) mem[ea] = ewd;
      checks++;
      if (dv !== (g ? 2'b10 : 2'b01) || lat !== 3 + waits) begin
        failures++; $display("FAIL rnd_grant[%0d]: got done=%b lat=%0d expected grant %0d lat %0d", i, dv, lat, g, 3 + waits);
      end
      checks++;
      if (oa !== ea || owr !== ewr || (ewr && ow !== ewd) || st_ok !== 1'b1 || s_ok !== 1'b1) begin
        failures++; $display("FAIL rnd_bus[%0d]: got addr=%0h wr=%b wdata=%0h expected %0h %b %0h", i, oa, owr, ow, ea, ewr, ewd);
      end
      checks++;
      if (err !== se || rdata !== m_rdata) begin
        failures++; $display("FAIL rnd_resp[%0d]: got err=%b rdata=%0h expected %b %0h", i, err, rdata, se, m_rdata);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int lat; logic [1:0] dv, da; logic [AW-1:0] oa; logic [DW-1:0] ow;
    logic owr, s_ok, st_ok, c_ok; bit seen; bit pulsed;
    wr[0] = 1'b0; addr0 = 6'd9; Pready = 1'b0; req = 2'b01; seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge Pclk); #1;
      if (Penable === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_reach_access: got 0 expected 1"); end
    #2 Prst = 1'b1;
    #1;
    checks++;
    if ({Pselx, Penable, done, err} !== 5'b0 || Paddr !== '0 || rdata !== '0) begin
      failures++; $display("FAIL rst_async: got sel=%b en=%b done=%b err=%b addr=%0h expected 0", Pselx, Penable, done, err, Paddr);
    end
    pulsed = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge Pclk); #1;
      if (done !== 2'b00) pulsed = 1'b1;
    end
    checks++; if (pulsed) begin failures++; $display("FAIL rst_no_done: got 1 expected 0"); end
    req = 2'b10; wr[1] = 1'b1; addr1 = 6'd33; wdata1 = DW'($urandom);
    Prst = 1'b0;
    m_last = 1'b1; m_rdata = '0;
    xfer(2'b10, 0, 1'b0, 32'h0, lat, dv, da, oa, ow, owr, s_ok, st_ok, c_ok);
    m_last = 1'b1;
    checks++;
    if (dv !== 2'b10 || lat !== 3 || oa !== 6'd33 || err !== 1'b0) begin
      failures++; $display("FAIL rst_regrant: got done=%b lat=%0d addr=%0h err=%b expected 10 3 21 0", dv, lat, oa, err);
    end
  endtask

  task automatic test_timeout();
    int lat; logic [1:0] dv, da; logic [AW-1:0] oa; logic [DW-1:0] ow;
    logic owr, s_ok, st_ok, c_ok; logic [DW-1:0] prd;
    prd = DW'($urandom) | 32'h1;
    wr[0] = 1'b0; addr0 = 6'd7;
    xfer(2'b01, 0, 1'b0, prd, lat, dv, da, oa, ow, owr, s_ok, st_ok, c_ok);
    m_rdata = prd;
    checks++; if (rdata !== m_rdata) begin failures++; $display("FAIL to_pre_read: got %0h expected %0h", rdata, m_rdata); end
    xfer(2'b01, 100000, 1'b0, 32'hDEAD_BEEF, lat, dv, da, oa, ow, owr, s_ok, st_ok, c_ok);
`ifdef APB_TIMEOUT_EN
    checks++;
    if (lat !== 2 + TO || dv !== 2'b01) begin
      failures++; $display("FAIL to_fire: got lat=%0d done=%b expected %0d 01", lat, dv, 2 + TO);
    end
    checks++;
    if (err !== 1'b1 || rdata !== '0) begin
      failures++; $display("FAIL to_resp: got err=%b rdata=%0h expected 1 0", err, rdata);
    end
`else
    checks++;
    if (lat !== -1 || dv !== 2'b00) begin
      failures++; $display("FAIL to_absent: got lat=%0d done=%b expected no completion", lat, dv);
    end
    checks++;
    if (Pselx !== 1'b1 || Penable !== 1'b1 || st_ok !== 1'b1) begin
      failures++; $display("FAIL to_wait: got sel=%b en=%b stable=%b expected 1 1 1", Pselx, Penable, st_ok);
    end
`endif
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_slverr();
    test_contention();
    test_random();
    test_reset_mid_access();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TO_CYCLES, default 16, wait-state limit (used only with APB_TIMEOUT_EN).
REQ-004 SHALL have ports as listed below. One clock; reset is asynchronous and active-high.
- Pclk  in  1  clock; all state updates on its rising edge.
- Prst  in  1  asynchronous, active-high reset.
- req  in  2  per-requester transfer request; bit i belongs to requester i.
- wr  in  2  per-requester direction; 1 = write.
- addr0, addr1  in  ADDR_W  per-requester address.
- wdata0, wdata1  in  DATA_W  per-requester write data.
- done  out  2  one-cycle completion pulse for the granted requester.
- rdata  out  DATA_W  read data of the last completed transfer.
- err  out  1  error status of the last completed transfer.
- Paddr  out  ADDR_W  APB address.
- Pselx  out  1  APB select.
- Penable  out  1  APB enable.
- Pwrite  out  1  APB direction.
- Pwdata  out  DATA_W  APB write data.
- Pready  in  1  APB slave ready.
- Pslverr  in  1  APB slave error.
- Prdata  in  DATA_W  APB read data.

Function
REQ-005 SHALL implement FSM states IDLE, SETUP, ACCESS, COMPLETE.
REQ-006 The requester contract SHALL be: hold req[i] and its wr/addr/wdata stable from assertion until done[i] is seen, then deassert req[i] in the done cycle.
REQ-007 In IDLE with any req bit high, the block SHALL grant one requester and latch its wr/addr/wdata into the output registers.
- It SHALL then go to SETUP on the next edge.
- It SHALL stay in IDLE when no req bit is high.
REQ-008 Arbitration SHALL be round-robin.
- On a tie, the requester not granted last time SHALL win.
- After reset, requester 0 SHALL win the first tie.
REQ-009 SETUP SHALL last exactly one cycle with Pselx=1 and Penable=0, then go to ACCESS.
REQ-010 ACCESS SHALL drive Pselx=1 and Penable=1. It SHALL stay in ACCESS while Pready=0 (wait states are unlimited unless REQ-016 applies).
REQ-011 When Pready=1 is sampled in ACCESS, the block SHALL:
- go to COMPLETE;
- register err<=Pslverr;
- register rdata<=Prdata for reads; for writes, leave rdata unchanged.
REQ-012 COMPLETE SHALL drive Pselx=0 and Penable=0, assert done[grant]=1 for exactly one cycle, then go to IDLE.
REQ-013 Paddr, Pwrite and Pwdata SHALL stay constant from SETUP through the end of ACCESS.
REQ-014 rdata and err SHALL hold their values until the next COMPLETE.
REQ-015 Latency SHALL be: req sampled in IDLE at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, done at cycle 3 (zero wait states). Each wait state adds one cycle. The minimum back-to-back period is 4 cycles.

Reset
REQ-017 Prst=1 SHALL immediately force:
- state to IDLE and the round-robin pointer to favour requester 0;
- Pselx, Penable, Pwrite, done and err to 0;
- Paddr, Pwdata and rdata to 0.
REQ-018 A reset during SETUP, ACCESS or COMPLETE SHALL abort the transfer with no done pulse.
- The requester SHALL re-issue the transfer after reset releases.
- The first arbitration after reset SHALL occur on the first rising edge with Prst=0.

Configuration
REQ-016 With macro APB_TIMEOUT_EN defined, the block SHALL count consecutive ACCESS cycles with Pready=0.
- When the count reaches TO_CYCLES, it SHALL go to COMPLETE with err=1 and rdata=0.
- The counter SHALL clear on every entry to SETUP.
REQ-019 With APB_TIMEOUT_EN undefined, no counter SHALL exist and ACCESS SHALL wait for Pready indefinitely.

Structure
REQ-020 Package apb_arb_pkg SHALL hold the FSM state enum and the default constants ADDR_W=6, DATA_W=32 and TO_CYCLES=16.
REQ-021 Round-robin grant logic SHALL live in sub-module rr_arb2 (inputs req[1:0] and last-grant pointer; output grant index).

Verification
REQ-022 Single write: req=01, wr0=1, addr0=5, wdata0=32'hA5A5_0001, Pready=1 -> SETUP then ACCESS with Paddr=5 and Pwdata=A5A50001; done=01 at cycle 3; err=0.
REQ-023 Read back with wait states: req=01, wr0=0, addr0=5, slave returns Pready=1 after 2 wait cycles with Prdata=A5A50001 -> done at cycle 5; rdata=A5A50001.
REQ-024 Contention: req=11 held continuously across 4 transfers -> grant order 0,1,0,1; Pselx=0 in every COMPLETE cycle.
REQ-025 Slave error: write with Pslverr=1 at Pready -> err=1 at done. A following good read -> err=0.
REQ-026 Reset mid-ACCESS: Prst=1 while Penable=1 -> Pselx=0 and Penable=0 immediately; no done pulse; after release, req=10 is granted first and normal completion follows.
REQ-027 With APB_TIMEOUT_EN: Pready tied to 0 -> after 16 ACCESS cycles, done pulses with err=1 and rdata=0. Without the macro -> the block remains in ACCESS.
